motor_drive_sequencer: RTL and testbench
========================================

MOTOR_DRIVE_SEQUENCER -- requirements
Module: motor_drive_sequencer

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 256: clocks per 1-LSB duty step.
REQ-002 SHALL have parameter DEAD_CYCLES, default 64: all-off clocks inserted before IDLE.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_dir  in  1  requested direction, 0=A, 1=B.
REQ-007 SHALL have port cmd_duty  in  8  requested target duty, 0..255.
REQ-008 SHALL have port estop  in  1  emergency stop, level-sensitive, synchronous.
REQ-009 SHALL have port cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-010 SHALL have port out_a  out  1  H-bridge leg A drive (registered).
REQ-011 SHALL have port out_b  out  1  H-bridge leg B drive (registered).
REQ-012 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-013 SHALL have port state_o  out  3  IDLE=0, RAMP=1, RUN=2, BRAKE=3, DEAD=4.
REQ-014 SHALL have port duty_o  out  8  current applied duty.

Function
REQ-015 SHALL keep internal registers dir_cur, duty_cur[7:0], target[7:0], pend_dir, pend_duty[7:0], pend_flag.
REQ-016 SHALL run free-running PWM counter pwm_cnt 0..254, wrapping 254->0 (period 255 clocks).
REQ-017 SHALL register drive = (pwm_cnt < duty_cur); out_a = drive & ~dir_cur, out_b = drive & dir_cur, both one cycle after duty/dir change; duty 0 = never on, duty 255 = always on.
REQ-018 SHALL never assert out_a and out_b in the same cycle.
REQ-019 SHALL drive cmd_ready = 1 only in IDLE or RUN with estop low; 0 in RAMP, BRAKE, DEAD.
REQ-020 SHALL use ramp prescaler counting 0..RAMP_DIV-1 in RAMP/BRAKE, cleared to 0 in other states; tick when count = RAMP_DIV-1.
REQ-021 IDLE: on accept with cmd_duty>0 -> dir_cur<=cmd_dir, target<=cmd_duty, go RAMP; cmd_duty=0 accepted, no state change.
REQ-022 RAMP: on tick, duty_cur steps +/-1 toward target; when duty_cur==target -> RUN if target>0, DEAD if target=0.
REQ-023 RUN, accept same dir: target<=cmd_duty, go RAMP (target equal to duty_cur -> stay RUN).
REQ-024 RUN, accept opposite dir: pend_dir/pend_duty latched, pend_flag<=1, go BRAKE.
REQ-025 BRAKE: on tick duty_cur -1; at duty_cur==0 -> DEAD.
REQ-026 DEAD: duty_cur=0, outputs low for exactly DEAD_CYCLES clocks; then if pend_flag and pend_duty>0 -> dir_cur<=pend_dir, target<=pend_duty, clear pend_flag, go RAMP; else clear pend_flag, go IDLE.
REQ-027 estop high in any state: next edge duty_cur<=0, target<=0, pend_flag<=0, state DEAD; DEAD counter held at 0 while estop high; countdown starts on estop low, then IDLE.
REQ-028 cmd_valid simultaneous with estop SHALL be ignored.
REQ-029 duty_cur SHALL never wrap below 0 or above 255.

Reset
REQ-030 On rst_n low, immediately: state IDLE, duty_cur 0, target 0, dir_cur 0, pend_flag 0, pwm_cnt 0, prescaler 0, dead counter 0, out_a 0, out_b 0, busy 0, cmd_ready 1 after release.
REQ-031 Reset mid-ramp or mid-DEAD SHALL abandon operation with no output glitch high.

Verification (RAMP_DIV=4, DEAD_CYCLES=8)
REQ-032 IDLE, cmd dir=0 duty=10 -> RAMP, duty_o reaches 10 after 40 clocks, state RUN, out_a high 10 of every 255 clocks, out_b 0.
REQ-033 RUN dir=0 duty=10, cmd dir=1 duty=5 -> BRAKE to 0 in 40 clocks, 8 clocks both low, RAMP dir=1 to 5 in 20 clocks, out_a never high after reversal.
REQ-034 RUN duty=3, estop pulse 1 clock -> outputs low within 2 clocks, 8 DEAD clocks, IDLE, duty_o=0, pending discarded.
REQ-035 cmd_valid held during RAMP -> cmd_ready 0, command not taken until RUN, then accepted in first RUN cycle.
REQ-036 duty=255 -> out_a constantly high in RUN; duty=0 in IDLE -> accepted, state stays IDLE.
REQ-037 rst_n low during BRAKE at duty 6 -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/motor_drive_sequencer.sv
`timescale 1ns/1ps
// Motor drive sequencer: H-bridge PWM with duty ramping, reversal braking,
// dead-time insertion and emergency stop.
module motor_drive_sequencer #(
    parameter int unsigned RAMP_DIV    = 256,
    parameter int unsigned DEAD_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_duty,
    input  logic       estop,
    output logic       cmd_ready,
    output logic       out_a,
    output logic       out_b,
    output logic       busy,
    output logic [2:0] state_o,
    output logic [7:0] duty_o
);

    localparam int unsigned PW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DW      = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned DUTY_W  = 8;
    localparam logic [DUTY_W-1:0] PWM_LAST = DUTY_W'(254);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic                pend_dir_q, pend_dir_d;
    logic [DUTY_W-1:0]   pend_duty_q, pend_duty_d;
    logic                pend_flag_q, pend_flag_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic [DUTY_W-1:0]   pwm_cnt_q;
    logic                out_a_q, out_b_q;

    logic                tick;
    logic                accept;
    logic                drive;
    logic [DUTY_W-1:0]   duty_up;
    logic [DUTY_W-1:0]   duty_dn;

    assign tick    = (presc_q == PW'(RAMP_DIV - 1));
    assign accept  = cmd_valid & cmd_ready;
    assign duty_up = duty_q + DUTY_W'(1);
    assign duty_dn = duty_q - DUTY_W'(1);

    // Commands are only taken in settled states and never alongside estop.
    assign cmd_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !estop;
    assign busy      = (state_q != ST_IDLE);
    assign state_o   = state_q;
    assign duty_o    = duty_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        duty_d      = duty_q;
        target_d    = target_q;
        pend_dir_d  = pend_dir_q;
        pend_duty_d = pend_duty_q;
        pend_flag_d = pend_flag_q;
        presc_d     = presc_q;
        dead_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_duty != '0)) begin
                    dir_d    = cmd_dir;
                    target_d = cmd_duty;
                    state_d  = ST_RAMP;
                end
            end
            ST_RAMP: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (duty_q == target_q) begin
                    state_d = (target_q != '0) ? ST_RUN : ST_DEAD;
                end else if (tick) begin
                    duty_d = (duty_q < target_q) ? duty_up : duty_dn;
                    if (duty_d == target_q) begin
                        state_d = (target_q != '0) ? ST_RUN : ST_DEAD;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (cmd_dir == dir_q) begin
                        target_d = cmd_duty;
                        if (cmd_duty != duty_q) begin
                            state_d = ST_RAMP;
                        end
                    end else begin
                        pend_dir_d  = cmd_dir;
                        pend_duty_d = cmd_duty;
                        pend_flag_d = 1'b1;
                        state_d     = ST_BRAKE;
                    end
                end
            end
            ST_BRAKE: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (duty_q == '0) begin
                    state_d = ST_DEAD;
                end else if (tick) begin
                    duty_d = duty_dn;
                    if (duty_dn == '0) begin
                        state_d = ST_DEAD;
                    end
                end
            end
            ST_DEAD: begin
                duty_d = '0;
                if (dead_q == DW'(DEAD_CYCLES - 1)) begin
                    pend_flag_d = 1'b0;
                    if (pend_flag_q && (pend_duty_q != '0)) begin
                        dir_d    = pend_dir_q;
                        target_d = pend_duty_q;
                        state_d  = ST_RAMP;
                    end else begin
                        target_d = '0;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Emergency stop overrides everything and pins the dead timer at zero.
        if (estop) begin
            state_d     = ST_DEAD;
            duty_d      = '0;
            target_d    = '0;
            pend_flag_d = 1'b0;
            dead_d      = '0;
        end

        // Prescaler only runs while ramping or braking.
        if ((state_d != ST_RAMP) && (state_d != ST_BRAKE)) begin
            presc_d = '0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            duty_q      <= '0;
            target_q    <= '0;
            pend_dir_q  <= 1'b0;
            pend_duty_q <= '0;
            pend_flag_q <= 1'b0;
            presc_q     <= '0;
            dead_q      <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            pend_dir_q  <= pend_dir_d;
            pend_duty_q <= pend_duty_d;
            pend_flag_q <= pend_flag_d;
            presc_q     <= presc_d;
            dead_q      <= dead_d;
        end
    end

    // Free-running PWM counter, period 255 clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + DUTY_W'(1);
        end
    end

    // Legs are blanked whenever the sequencer is heading into dead time.
    assign drive = (pwm_cnt_q < duty_q) && (state_d != ST_DEAD);

    // Registered H-bridge leg drives; mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_q <= 1'b0;
            out_b_q <= 1'b0;
        end else begin
            out_a_q <= drive & ~dir_q;
            out_b_q <= drive & dir_q;
        end
    end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
`timescale 1ns/1ps
// Scoreboarded random test of motor_drive_sequencer against a transaction-level model.
module tb_motor_drive_sequencer;

    localparam int R = 4;
    localparam int D = 8;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RAMP  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_BRAKE = 3'd3;
    localparam logic [2:0] S_DEAD  = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_duty = 8'd0;
    logic       estop = 1'b0;
    logic       cmd_ready;
    logic       out_a;
    logic       out_b;
    logic       busy;
    logic [2:0] state_o;
    logic [7:0] duty_o;

    motor_drive_sequencer #(.RAMP_DIV(R), .DEAD_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_duty(cmd_duty), .estop(estop), .cmd_ready(cmd_ready),
        .out_a(out_a), .out_b(out_b), .busy(busy), .state_o(state_o), .duty_o(duty_o)
    );

    always #5 clk = ~clk;

    // Expected state transition: new state, duty seen on entry, cycles spent in the previous state.
    typedef struct {
        logic [2:0] st;
        int         duty;
        int         dwell;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Model of the settled motor condition.
    bit  m_run  = 1'b0;
    bit  m_dir  = 1'b0;
    int  m_duty = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [2:0] st, input int duty, input int dwell);
        ev_t e;
        e.st = st; e.duty = duty; e.dwell = dwell;
        sb.push_back(e);
    endfunction

    // Predict the transition sequence a command produces; returns 1 if any.
    function automatic bit plan_cmd(input bit d, input int x, input int fd);
        int c;
        c = m_duty;
        if (!m_run) begin
            if (x == 0) return 1'b0;
            push(S_RAMP, 0, fd);
            push(S_RUN, x, x * R);
            m_run = 1'b1; m_dir = d; m_duty = x;
            return 1'b1;
        end
        if (d == m_dir) begin
            if (x == c) return 1'b0;
            push(S_RAMP, c, fd);
            if (x > 0) begin
                push(S_RUN, x, ((x > c) ? (x - c) : (c - x)) * R);
                m_duty = x;
            end else begin
                push(S_DEAD, 0, c * R);
                push(S_IDLE, 0, D);
                m_run = 1'b0; m_duty = 0;
            end
            return 1'b1;
        end
        push(S_BRAKE, c, fd);
        push(S_DEAD, 0, c * R);
        if (x > 0) begin
            push(S_RAMP, 0, D);
            push(S_RUN, x, x * R);
            m_dir = d; m_duty = x;
        end else begin
            push(S_IDLE, 0, D);
            m_run = 1'b0; m_duty = 0;
        end
        return 1'b1;
    endfunction

    // Offer a command and hold it until it is taken.
    task automatic send(input bit d, input int x, output int waited, output int st_acc);
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = d; cmd_duty = 8'(x);
        while (!cmd_ready && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_accept_timeout", int'(cmd_ready), 1);
        st_acc = int'(state_o);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for all predicted transitions, then confirm the settled condition.
    task automatic settle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk("settle_pending_events", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk("settled_state", int'(state_o), int'(m_run ? S_RUN : S_IDLE));
        chk("settled_duty", int'(duty_o), m_duty);
    endtask

    // Count leg high-time over one full PWM period.
    task automatic measure();
        int ca;
        int cb;
        ca = 0; cb = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            ca += int'(out_a);
            cb += int'(out_b);
        end
        chk("pwm_a_highs", ca, (m_run && !m_dir) ? m_duty : 0);
        chk("pwm_b_highs", cb, (m_run && m_dir) ? m_duty : 0);
    endtask

    // Emergency stop of k clocks, optionally with a competing command.
    task automatic do_estop(input int k, input bit with_cmd);
        push(S_DEAD, 0, -1);
        push(S_IDLE, 0, D + k - 1);
        m_run = 1'b0; m_duty = 0;
        @(negedge clk);
        estop = 1'b1;
        if (with_cmd) begin
            cmd_valid = 1'b1;
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_duty  = 8'($urandom_range(1, 255));
        end
        repeat (k) @(negedge clk);
        estop = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // Monitor: per-cycle invariants plus in-order transition scoreboard.
    initial begin : monitor
        logic [2:0] prev;
        int         cyc;
        int         last;
        ev_t        e;
        prev = S_IDLE; cyc = 0; last = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                chk("reset_out_a", int'(out_a), 0);
                chk("reset_out_b", int'(out_b), 0);
                prev = S_IDLE;
                last = cyc;
            end else begin
                chk("legs_exclusive", int'(out_a & out_b), 0);
                chk("busy", int'(busy), int'(state_o != S_IDLE));
                chk("cmd_ready", int'(cmd_ready),
                    int'((state_o == S_IDLE || state_o == S_RUN) && !estop));
                if (state_o == S_DEAD) chk("dead_outputs", int'(out_a | out_b), 0);
                if (state_o != prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_state_change", int'(state_o), int'(prev));
                    end else begin
                        e = sb.pop_front();
                        chk("state_seq", int'(state_o), int'(e.st));
                        chk("duty_at_transition", int'(duty_o), e.duty);
                        if (e.dwell >= 0) chk("dwell_cycles", cyc - last, e.dwell);
                    end
                    prev = state_o;
                    last = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: time limit reached with %0d events pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w, sa, r, x, x2, t;
        bit d, d2, p;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_state", int'(state_o), int'(S_IDLE));
        chk("rst_duty", int'(duty_o), 0);
        chk("rst_out_a", int'(out_a), 0);
        chk("rst_out_b", int'(out_b), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);

        // Forward ramp to 10, then reversal to 5, then same-direction trim to 3.
        void'(plan_cmd(1'b0, 10, -1)); send(1'b0, 10, w, sa); settle(); measure();
        void'(plan_cmd(1'b1, 5, -1));  send(1'b1, 5, w, sa);  settle(); measure();
        void'(plan_cmd(1'b1, 3, -1));  send(1'b1, 3, w, sa);  settle();

        // One-clock estop from RUN.
        do_estop(1, 1'b0); settle(); measure();

        // Zero duty in IDLE is taken without leaving IDLE.
        void'(plan_cmd(1'b0, 0, -1)); send(1'b0, 0, w, sa);
        chk("zero_cmd_wait", w, 0);
        repeat (20) @(negedge clk);
        chk("zero_cmd_stays_idle", int'(state_o), int'(S_IDLE));

        // Full duty: leg A constantly on.
        void'(plan_cmd(1'b0, 255, -1)); send(1'b0, 255, w, sa); settle(); measure();

        // Command held during a ramp is taken in the first RUN cycle.
        void'(plan_cmd(1'b0, 20, -1)); send(1'b0, 20, w, sa);
        void'(plan_cmd(1'b0, 25, 1));  send(1'b0, 25, w, sa);
        chk("held_cmd_waited", int'(w > 0), 1);
        chk("held_cmd_taken_in_run", sa, int'(S_RUN));
        settle(); measure();

        // Reset while braking at duty 6.
        void'(plan_cmd(1'b1, 10, -1)); send(1'b1, 10, w, sa);
        t = 0;
        while (!(state_o == S_BRAKE && duty_o == 8'd6) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("brake_reached_6", int'(state_o == S_BRAKE && duty_o == 8'd6), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state_o), int'(S_IDLE));
        chk("async_rst_duty", int'(duty_o), 0);
        chk("async_rst_out_a", int'(out_a), 0);
        chk("async_rst_out_b", int'(out_b), 0);
        chk("async_rst_busy", int'(busy), 0);
        sb.delete();
        m_run = 1'b0; m_dir = 1'b0; m_duty = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", int'(state_o), int'(S_IDLE));
        chk("post_rst_ready", int'(cmd_ready), 1);

        // Randomised commands and estops.
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                do_estop($urandom_range(1, 3), 1'($urandom_range(0, 1)));
                settle();
            end else begin
                d = 1'($urandom_range(0, 1));
                x = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
                p = plan_cmd(d, x, -1);
                send(d, x, w, sa);
                if (p && m_run && $urandom_range(0, 3) == 0) begin
                    d2 = 1'($urandom_range(0, 1));
                    x2 = $urandom_range(0, 255);
                    void'(plan_cmd(d2, x2, 1));
                    send(d2, x2, w, sa);
                    chk("early_cmd_taken_in_run", sa, int'(S_RUN));
                end
                settle();
                if ($urandom_range(0, 1) == 1) measure();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
